// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (one quotient bit per clock) with start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement signed division; unsigned otherwise.
module seq_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] rem_r, quo_r, div_r;
  logic [CNT_W-1:0] count;
  logic             dvd_neg, dvs_neg, dbz_r;

  logic             dvd_sign, dvs_sign;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] trial;
  logic             trial_ge;
  logic             last_iter;

`ifdef DIV_SIGNED_EN
  assign dvd_sign = dividend[WIDTH-1];
  assign dvs_sign = divisor[WIDTH-1];
`else
  assign dvd_sign = 1'b0;
  assign dvs_sign = 1'b0;
`endif

  assign dvd_abs = dvd_sign ? -dividend : dividend;
  assign dvs_abs = dvs_sign ? -divisor  : divisor;

  // Shifted remainder is WIDTH+1 bits; when the trial fits, the difference is < div_r,
  // so the low WIDTH bits of the subtraction are exact.
  assign rem_sh    = {rem_r, quo_r[WIDTH-1]};
  assign trial_ge  = (rem_sh >= {1'b0, div_r});
  assign trial     = rem_sh[WIDTH-1:0] - div_r;
  assign last_iter = (count == CNT_W'(WIDTH - 1));

  assign busy = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (divisor == '0) ? FIX : CALC;
      CALC: if (last_iter) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      rem_r       <= '0;
      quo_r       <= '0;
      div_r       <= '0;
      count       <= '0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      dbz_r       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem_r   <= '0;
            quo_r   <= dvd_abs;
            div_r   <= dvs_abs;
            count   <= '0;
            dvd_neg <= dvd_sign;
            dvs_neg <= dvs_sign;
            dbz_r   <= (divisor == '0);
          end
        end
        CALC: begin
          quo_r <= {quo_r[WIDTH-2:0], trial_ge};
          rem_r <= trial_ge ? trial : rem_sh[WIDTH-1:0];
          count <= count + CNT_W'(1);
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dbz_r;
          if (dbz_r) begin
            // quo_r still holds |dividend|; re-applying the sign restores the original operand
            quotient  <= '1;
            remainder <= dvd_neg ? -quo_r : quo_r;
          end else begin
            quotient  <= (dvd_neg ^ dvs_neg) ? -quo_r : quo_r;
            remainder <= dvd_neg ? -rem_r : rem_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor checks each done pulse.
module tb_seq_divider;

  logic        Clock = 1'b0;
  logic        clear, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  always #5 Clock = ~Clock;

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .Clock       (Clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(negedge Clock) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 required no pending result (q=%h r=%h)",
                 quotient, remainder);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
      end
    end
  end

  // Caller positions time mid-cycle; inputs are scrambled after acceptance.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic dbz,
                         input int lat, input int bsy, input string tag);
    int n, bc;
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz;
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    n = 0; bc = 0;
    while (n < 100) begin
      if (busy) bc++;
      @(posedge Clock);
      n++;
      #1;
      if (done) break;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_cycles"}, bc, bsy);
  endtask

  initial begin : stim
    int n;
    exp_t e;
    clear = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge Clock);
    clear = 1'b0;

    @(negedge Clock);
    run_div(32'd12, 32'd2, 32'd6, 32'd0, 1'b0, 33, 33, "t1");

    @(negedge Clock);
`ifdef DIV_SIGNED_EN
    run_div(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, 33, "t2_signed");
`else
    run_div(32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 33, 33, "t2_unsigned");
`endif

    @(negedge Clock);
    run_div(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1, 1, "t3_dbz");
    repeat (3) @(posedge Clock);
    #1;
    check("t3_dbz_held", {31'b0, div_by_zero}, 32'd1);
    check("t3_rem_held", remainder, 32'd5);
    @(negedge Clock);
    run_div(32'd12, 32'd2, 32'd6, 32'd0, 1'b0, 33, 33, "t3_clear_dbz");

    @(negedge Clock);
`ifdef DIV_SIGNED_EN
    run_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33, 33, "t6_min_neg1");
    @(negedge Clock);
    run_div(32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 33, 33, "neg_neg");
`else
    run_div(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33, 33, "t6_unsigned");
    @(negedge Clock);
    run_div(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 33, 33, "max_by_one");
`endif

    // start held through the done cycle is accepted at that edge
    @(negedge Clock);
    run_div(32'd20, 32'd4, 32'd5, 32'd0, 1'b0, 33, 33, "b2b_first");
    run_div(32'd21, 32'd5, 32'd4, 32'd1, 1'b0, 33, 33, "b2b_second");

    // re-pulse start mid-operation: must be ignored
    @(negedge Clock);
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    e.q = 32'd14; e.r = 32'd2; e.dbz = 1'b0;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    start = 1'b0;
    n = 0;
    repeat (9) begin @(posedge Clock); n++; end
    @(negedge Clock);
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge Clock);
    n++;
    #1;
    start = 1'b0;
    while (n < 100) begin
      @(posedge Clock);
      n++;
      #1;
      if (done) break;
    end
    check("t4_latency", n, 33);
    repeat (40) @(posedge Clock);

    // clear mid-division aborts with no done
    @(negedge Clock);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge Clock);
    #1;
    start = 1'b0;
    repeat (14) @(posedge Clock);
    @(negedge Clock);
    clear = 1'b1;
    @(posedge Clock);
    #1;
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_done", {31'b0, done}, 32'd0);
    check("t5_quotient", quotient, 32'd0);
    check("t5_remainder", remainder, 32'd0);
    check("t5_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge Clock);
    clear = 1'b0;
    repeat (40) @(posedge Clock);
    @(negedge Clock);
    run_div(32'd12, 32'd2, 32'd6, 32'd0, 1'b0, 33, 33, "t5_restart");

    repeat (3) @(posedge Clock);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
